// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: integer writeback always wins, long-latency
// results queue in a small FIFO with valid/ready back-pressure. Integer issues
// squash older queued writes to the same register.
// Optional macro WB_LU_BYPASS_EN: an lu result skips the FIFO when nothing
// live is queued and no integer write is requested.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          int_we,
    input  logic [4:0]    int_wn,
    input  logic [31:0]   int_d,
    input  logic          lu_valid,
    input  logic [4:0]    lu_wn,
    input  logic [31:0]   lu_d,
    output logic          lu_ready,
    output logic          we,
    output logic [4:0]    wn,
    output logic [31:0]   d,
    output logic [31:0]   pend,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]       ent_wn [DEPTH];
    logic [31:0]      ent_d  [DEPTH];
    logic [DEPTH-1:0] ent_v;
    logic [AW-1:0]    rp;
    logic [AW-1:0]    wp;

    logic int_req;
    logic push;
    logic store;
    logic pop;
    logic head_live;
    logic any_live;
    logic byp;

    // Request decode, handshake and pop/bypass selection
    always_comb begin
        int_req   = int_we && (int_wn != 5'd0);
        lu_ready  = (fifo_count < FULL);
        push      = lu_valid && lu_ready;
        head_live = ent_v[rp];
        any_live  = |ent_v;
        // A dead head is dropped regardless of the integer path; a live one
        // leaves only when it is the selected source.
        pop       = (fifo_count != '0) && (!ent_v[rp] || !int_req);
`ifdef WB_LU_BYPASS_EN
        byp       = push && (lu_wn != 5'd0) && !int_req && !any_live;
`else
        byp       = 1'b0;
`endif
        store     = push && (lu_wn != 5'd0) && !byp;
    end

    // Pending-destination bitmap from live queue entries
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_v[AW'(i)]) pend[ent_wn[AW'(i)]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    // Output registers, FIFO storage, squash and pointer/count update
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            we         <= 1'b0;
            wn         <= '0;
            d          <= '0;
            rp         <= '0;
            wp         <= '0;
            ent_v      <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_wn[AW'(i)] <= '0;
                ent_d[AW'(i)]  <= '0;
            end
        end else begin
            if (int_req) begin
                we <= 1'b1;
                wn <= int_wn;
                d  <= int_d;
            end else if (head_live) begin
                we <= 1'b1;
                wn <= ent_wn[rp];
                d  <= ent_d[rp];
            end else if (byp) begin
                we <= 1'b1;
                wn <= lu_wn;
                d  <= lu_d;
            end else begin
                we <= 1'b0;
            end

            // Squash first, then pop, then push: the entry written this
            // cycle lands after the squash and so is never killed by it.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (int_req && ent_v[AW'(i)] && (ent_wn[AW'(i)] == int_wn))
                    ent_v[AW'(i)] <= 1'b0;
            end
            if (pop) begin
                ent_v[rp] <= 1'b0;
                rp        <= rp + AW'(1);
            end
            if (store) begin
                ent_v[wp]  <= 1'b1;
                ent_wn[wp] <= lu_wn;
                ent_d[wp]  <= lu_d;
                wp         <= wp + AW'(1);
            end
            fifo_count <= fifo_count + CW'(store) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter; expected values are hand-computed.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        clrn;
    logic        int_we;
    logic [4:0]  int_wn;
    logic [31:0] int_d;
    logic        lu_valid;
    logic [4:0]  lu_wn;
    logic [31:0] lu_d;
    logic        lu_ready;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic [31:0] pend;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    wb_write_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .clrn(clrn),
        .int_we(int_we), .int_wn(int_wn), .int_d(int_d),
        .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_d(lu_d), .lu_ready(lu_ready),
        .we(we), .wn(wn), .d(d), .pend(pend), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        int_we = 1'b0; int_wn = '0; int_d = '0;
        lu_valid = 1'b0; lu_wn = '0; lu_d = '0;
    endtask

    // push r1..r4 (d=0x10..0x13) while the integer path writes r9
    task automatic fill_four();
        int_we = 1'b1; int_wn = 5'd9; int_d = 32'h99;
        lu_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            lu_wn = 5'(k);
            lu_d  = 32'h10 + 32'(k - 1);
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        clrn = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_we",    32'(we), 32'd0);
        check("rst_wn",    32'(wn), 32'd0);
        check("rst_d",     d, 32'd0);
        check("rst_pend",  pend, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        clrn = 1'b1;
        check("rst_ready", 32'(lu_ready), 32'd1);

        // 1: integer write
        int_we = 1'b1; int_wn = 5'd5; int_d = 32'hDEADBEEF;
        step();
        check("t1_we", 32'(we), 32'd1);
        check("t1_wn", 32'(wn), 32'd5);
        check("t1_d",  d, 32'hDEADBEEF);
        idle_inputs();
        step();
        check("t1_we_off", 32'(we), 32'd0);
        check("t1_wn_hold", 32'(wn), 32'd5);

        // 2: fill under integer pressure, then drain in order
        fill_four();
        check("t2_count_full", 32'(fifo_count), 32'd4);
        check("t2_ready_full", 32'(lu_ready), 32'd0);
        check("t2_pend", pend, 32'h1E);
        check("t2_int_wn", 32'(wn), 32'd9);
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t2_drain_we", 32'(we), 32'd1);
            check("t2_drain_wn", 32'(wn), 32'(k));
            check("t2_drain_d",  d, 32'h10 + 32'(k - 1));
            check("t2_drain_cnt", 32'(fifo_count), 32'(4 - k));
        end
        step();
        check("t2_idle_we", 32'(we), 32'd0);

        // 3: squash of a queued r7 by an integer r7 write
        int_we = 1'b1; int_wn = 5'd9; int_d = 32'h1;
        lu_valid = 1'b1; lu_wn = 5'd7; lu_d = 32'hAA;
        step();
        check("t3_pend7", pend, 32'h80);
        check("t3_cnt1", 32'(fifo_count), 32'd1);
        lu_valid = 1'b0;
        int_wn = 5'd7; int_d = 32'hBB;
        step();
        check("t3_we", 32'(we), 32'd1);
        check("t3_wn", 32'(wn), 32'd7);
        check("t3_d",  d, 32'hBB);
        check("t3_pend_clr", pend, 32'd0);
        check("t3_cnt_still1", 32'(fifo_count), 32'd1);
        idle_inputs();
        step();
        check("t3_dead_we", 32'(we), 32'd0);
        check("t3_dead_cnt", 32'(fifo_count), 32'd0);

        // 4: lu_wn=0 accepted but dropped; int_wn=0 is no request
        lu_valid = 1'b1; lu_wn = 5'd0; lu_d = 32'h77;
        check("t4_ready", 32'(lu_ready), 32'd1);
        step();
        check("t4_cnt0", 32'(fifo_count), 32'd0);
        check("t4_we0", 32'(we), 32'd0);
        int_we = 1'b1; int_wn = 5'd9; int_d = 32'h2;
        lu_wn = 5'd3; lu_d = 32'h33;
        step();
        check("t4_pend3", pend, 32'h08);
        lu_valid = 1'b0;
        int_wn = 5'd0; int_d = 32'h44;
        step();
        check("t4_we", 32'(we), 32'd1);
        check("t4_wn", 32'(wn), 32'd3);
        check("t4_d",  d, 32'h33);
        check("t4_cnt", 32'(fifo_count), 32'd0);
        idle_inputs();
        step();

        // 5: asynchronous reset mid-drain
        fill_four();
        idle_inputs();
        step();
        check("t5_cnt3", 32'(fifo_count), 32'd3);
        #2 clrn = 1'b0;
        #1;
        check("t5_we", 32'(we), 32'd0);
        check("t5_cnt", 32'(fifo_count), 32'd0);
        check("t5_pend", pend, 32'd0);
        check("t5_wn", 32'(wn), 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        check("t5_ready", 32'(lu_ready), 32'd1);

        // 6: single lu push into an idle arbiter
        lu_valid = 1'b1; lu_wn = 5'd12; lu_d = 32'h55;
        step();
        lu_valid = 1'b0;
`ifdef WB_LU_BYPASS_EN
        check("t6_we", 32'(we), 32'd1);
        check("t6_wn", 32'(wn), 32'd12);
        check("t6_d",  d, 32'h55);
        check("t6_cnt", 32'(fifo_count), 32'd0);
        step();
        check("t6_we_off", 32'(we), 32'd0);
`else
        check("t6_we_early", 32'(we), 32'd0);
        check("t6_cnt", 32'(fifo_count), 32'd1);
        check("t6_pend", pend, 32'h1000);
        step();
        check("t6_we", 32'(we), 32'd1);
        check("t6_wn", 32'(wn), 32'd12);
        check("t6_d",  d, 32'h55);
        check("t6_cnt0", 32'(fifo_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 integer register file's single write port (outputs wn/d/we feed it directly).
- Merges two result sources: the in-order integer pipeline's writeback stage, and a long-latency unit port (FPU result mover / divider).
- Integer writes always win. Long-latency results wait in a small FIFO with valid/ready back-pressure.
- Exports a pending-destination bitmap for the hazard/interlock unit.

Parameters:
DEPTH, 4, long-latency FIFO entries; power of two, >= 2
CW, 3, width of fifo_count; must hold DEPTH (clog2(DEPTH+1))

Ports:
clk  in  1  clock, rising edge
clrn  in  1  reset, asynchronous, active-low
int_we  in  1  integer writeback request this cycle
int_wn  in  5  integer destination register
int_d  in  32  integer write data
lu_valid  in  1  long-latency result valid
lu_wn  in  5  long-latency destination register
lu_d  in  32  long-latency write data
lu_ready  out  1  FIFO can accept; lu_ready = (fifo_count < DEPTH), combinational
we  out  1  register-file write enable (registered)
wn  out  5  register-file write number (registered)
d  out  32  register-file write data (registered)
pend  out  32  bit i = 1 while a live, unissued FIFO entry targets register i; bit 0 is always 0
fifo_count  out  CW  entries in FIFO, including squashed entries

Behaviour:
- Reset, async on clrn low, including mid-operation:
  - we=0, wn=0, d=0.
  - FIFO emptied, read/write pointers 0, all entry valid bits 0.
  - pend=0, fifo_count=0.
  - Entries in flight are discarded; lu_ready=1 once clrn is released.
- Issue selection, evaluated each cycle and registered at the rising edge (priority order):
  1. int_we=1 and int_wn!=0: output {we=1, wn=int_wn, d=int_d}.
  2. Otherwise, FIFO head is live: output the head entry and pop it.
  3. Otherwise: we=0; wn/d hold their previous values.
- int_we=1 with int_wn=0 counts as no request; the FIFO may drain that cycle.
- Latency:
  - Integer input sampled at edge N appears on we/wn/d after edge N; the register file writes at edge N+1.
  - FIFO push at edge N can issue at edge N+1 at the earliest.
- Push:
  - Occurs when lu_valid && lu_ready.
  - lu_wn=0 is accepted (handshake completes) but not stored.
  - At full, lu_ready=0 even if a pop happens the same cycle; there is no same-cycle refill.
- Squash (write-after-write protection):
  - When the integer path issues to register X, every live FIFO entry with wn==X is marked dead at the same edge.
  - An entry being pushed in that same cycle is not squashed; it is treated as younger.
- Dead head:
  - Popped in any cycle, even while the integer path issues, with no write.
  - A live head is popped only when it is selected.
- fifo_count:
  - +1 on push, -1 on pop, unchanged on a simultaneous push and pop.
  - Never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH.
- pend is combinational: the OR over live entries of the one-hot decode of wn.
- Simultaneous int issue + lu push + live head: int issues, push occurs, head stays.

Optional Feature:
- Macro: WB_LU_BYPASS_EN.
- Defined: when the FIFO holds no live entry and there is no integer request, a lu push goes straight to the output registers at that edge. The FIFO is not written, fifo_count is unchanged, and latency is 1 cycle. lu_ready is unchanged.
- Undefined: every lu result passes through the FIFO; minimum latency is 2 cycles.

Test Plan:
1. Hold clrn=0, then release; pulse int_we=1, int_wn=5, int_d=0xDEADBEEF -> next edge: we=1, wn=5, d=0xDEADBEEF; following cycle with idle inputs: we=0.
2. Push four lu entries (wn=1..4, d=0x10..0x13) while int_we=1 to r9 each cycle -> fifo_count=4, lu_ready=0, pend=0x1E. Then drop int_we -> entries r1..r4 written in order over 4 cycles, fifo_count returns to 0.
3. FIFO holds r7/0xAA; int writes r7/0xBB -> we=1, wn=7, d=0xBB; pend[7] clears that edge; next cycle the dead head pops with we=0 and fifo_count goes 1->0.
4. lu push with lu_wn=0 -> lu_ready handshake completes; fifo_count stays 0; no write occurs. int_we=1, int_wn=0 with FIFO head r3 -> r3 is issued.
5. Fill FIFO, assert clrn=0 mid-drain -> we=0, fifo_count=0, pend=0 immediately, without waiting for a clock edge.
6. Idle FIFO, lu push r12/0x55: with WB_LU_BYPASS_EN, we=1 after the same edge; without it, we=1 one edge later.
